// File: rtl/bus_demux_fifo_if.sv
// Handshake bundle between a tagged input stream and two per-channel FWFT consumers.
// The slave modport belongs to the demux. The master modport belongs to whatever drives it.
interface bus_demux_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CW-1:0]    out0_count;
    logic [CW-1:0]    out1_count;

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid,
        output out0_count, out1_count
    );

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid,
        input  out0_count, out1_count
    );
endinterface

// File: rtl/bus_demux_fifo.sv
// Steers one tagged word stream into two independent first-word-fall-through FIFOs.
// A full channel back-pressures only the words addressed to it.
module bus_demux_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_demux_fifo_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("bus_demux_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_r    [2][DEPTH];
    logic [PW-1:0]    wr_ptr_r [2];
    logic [PW-1:0]    rd_ptr_r [2];
    logic [CW-1:0]    count_r  [2];

    logic [1:0] full_s;
    logic [1:0] nonempty_s;
    logic [1:0] push_s;
    logic [1:0] pop_s;
    logic       in_ready_s;

    // Full/empty flags and the per-channel push/pop strobes for this cycle.
    always_comb begin
        full_s     = 2'b00;
        nonempty_s = 2'b00;
        push_s     = 2'b00;
        pop_s      = 2'b00;
        in_ready_s = 1'b0;

        full_s[0]     = (count_r[0] == FULL_COUNT);
        full_s[1]     = (count_r[1] == FULL_COUNT);
        nonempty_s[0] = (count_r[0] != {CW{1'b0}});
        nonempty_s[1] = (count_r[1] != {CW{1'b0}});

        // Only the addressed channel's full flag matters; a pop this cycle does not free a slot early.
        if (bus.in_sel) begin
            in_ready_s = ~full_s[1];
        end else begin
            in_ready_s = ~full_s[0];
        end

        push_s[0] = bus.in_valid & in_ready_s & ~bus.in_sel;
        push_s[1] = bus.in_valid & in_ready_s &  bus.in_sel;
        pop_s[0]  = nonempty_s[0] & bus.out0_ready;
        pop_s[1]  = nonempty_s[1] & bus.out1_ready;
    end

    // Storage, pointers and occupancy for both channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_r[c] <= {PW{1'b0}};
                rd_ptr_r[c] <= {PW{1'b0}};
                count_r[c]  <= {CW{1'b0}};
                for (int e = 0; e < DEPTH; e++) begin
                    mem_r[c][e] <= {WIDTH{1'b0}};
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push_s[c]) begin
                    mem_r[c][wr_ptr_r[c]] <= bus.in_data;
                    wr_ptr_r[c]           <= wr_ptr_r[c] + PW'(1);
                end
                if (pop_s[c]) begin
                    rd_ptr_r[c] <= rd_ptr_r[c] + PW'(1);
                end
                // Full and empty come from this count, never from pointer comparison.
                case ({push_s[c], pop_s[c]})
                    2'b10:   count_r[c] <= count_r[c] + CW'(1);
                    2'b01:   count_r[c] <= count_r[c] - CW'(1);
                    default: count_r[c] <= count_r[c];
                endcase
            end
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out0_valid = nonempty_s[0];
    assign bus.out1_valid = nonempty_s[1];
    assign bus.out0_data  = mem_r[0][rd_ptr_r[0]];
    assign bus.out1_data  = mem_r[1][rd_ptr_r[1]];
    assign bus.out0_count = count_r[0];
    assign bus.out1_count = count_r[1];
endmodule

// File: tb/tb_bus_demux_fifo.sv
// Directed and randomized checks of the two-channel demux FIFO.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bus_demux_fifo;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    bus_demux_fifo_if #(.WIDTH(4), .DEPTH(4)) bus_if ();

    bus_demux_fifo #(.WIDTH(4), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sel, input logic [3:0] d);
        bus_if.in_valid = v;
        bus_if.in_sel   = sel;
        bus_if.in_data  = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), 1'($urandom), 4'($urandom));
            bus_if.out0_ready = 1'($urandom);
            bus_if.out1_ready = 1'($urandom);
            tick();
        end
        n_checks++; if (bus_if.out0_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out0_valid got %0h exp 0", bus_if.out0_valid); end
        n_checks++; if (bus_if.out1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out1_valid got %0h exp 0", bus_if.out1_valid); end
        n_checks++; if (bus_if.out0_count !== 3'd0) begin n_fail++; $display("FAIL rst_out0_count got %0d exp 0", bus_if.out0_count); end
        n_checks++; if (bus_if.out1_count !== 3'd0) begin n_fail++; $display("FAIL rst_out1_count got %0d exp 0", bus_if.out1_count); end
        n_checks++; if (bus_if.out0_data !== 4'h0) begin n_fail++; $display("FAIL rst_out0_data got %0h exp 0", bus_if.out0_data); end
        n_checks++; if (bus_if.out1_data !== 4'h0) begin n_fail++; $display("FAIL rst_out1_data got %0h exp 0", bus_if.out1_data); end
        n_checks++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0h exp 1", bus_if.in_ready); end
        drive(1'b0, 1'b0, 4'h0);
        bus_if.out0_ready = 1'b0;
        bus_if.out1_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        drive(1'b1, 1'b0, 4'hA);
        tick();
        drive(1'b0, 1'b0, 4'h0);
        n_checks++; if (bus_if.out0_valid !== 1'b1) begin n_fail++; $display("FAIL first_push_valid got %0h exp 1", bus_if.out0_valid); end
        n_checks++; if (bus_if.out0_data !== 4'hA) begin n_fail++; $display("FAIL first_push_data got %0h exp a", bus_if.out0_data); end
        n_checks++; if (bus_if.out1_valid !== 1'b0) begin n_fail++; $display("FAIL first_push_out1_valid got %0h exp 0", bus_if.out1_valid); end
        n_checks++; if (bus_if.out0_count !== 3'd1) begin n_fail++; $display("FAIL first_push_count got %0d exp 1", bus_if.out0_count); end
        bus_if.out0_ready = 1'b1;
        tick();
        bus_if.out0_ready = 1'b0;
        n_checks++; if (bus_if.out0_count !== 3'd0) begin n_fail++; $display("FAIL first_pop_count got %0d exp 0", bus_if.out0_count); end
    endtask

    task automatic test_steering;
        bus_if.out0_ready = 1'b0;
        bus_if.out1_ready = 1'b0;
        drive(1'b1, 1'b0, 4'h1); tick();
        drive(1'b1, 1'b1, 4'h2); tick();
        drive(1'b1, 1'b0, 4'h3); tick();
        drive(1'b0, 1'b0, 4'h0);
        n_checks++; if (bus_if.out0_count !== 3'd2) begin n_fail++; $display("FAIL steer_count0 got %0d exp 2", bus_if.out0_count); end
        n_checks++; if (bus_if.out1_count !== 3'd1) begin n_fail++; $display("FAIL steer_count1 got %0d exp 1", bus_if.out1_count); end
        n_checks++; if (bus_if.out0_data !== 4'h1) begin n_fail++; $display("FAIL steer_head0 got %0h exp 1", bus_if.out0_data); end
        n_checks++; if (bus_if.out1_data !== 4'h2) begin n_fail++; $display("FAIL steer_head1 got %0h exp 2", bus_if.out1_data); end
        bus_if.out0_ready = 1'b1;
        bus_if.out1_ready = 1'b1;
        tick();
        n_checks++; if (bus_if.out0_data !== 4'h3) begin n_fail++; $display("FAIL steer_second0 got %0h exp 3", bus_if.out0_data); end
        n_checks++; if (bus_if.out1_valid !== 1'b0) begin n_fail++; $display("FAIL steer_out1_drained got %0h exp 0", bus_if.out1_valid); end
        tick();
        n_checks++; if (bus_if.out0_count !== 3'd0) begin n_fail++; $display("FAIL steer_count0_end got %0d exp 0", bus_if.out0_count); end
        n_checks++; if (bus_if.out1_count !== 3'd0) begin n_fail++; $display("FAIL empty_pop_ignored got %0d exp 0", bus_if.out1_count); end
        // ready held high on an empty channel: the push must still land
        drive(1'b1, 1'b1, 4'h4); tick();
        drive(1'b0, 1'b0, 4'h0);
        n_checks++; if (bus_if.out1_count !== 3'd1) begin n_fail++; $display("FAIL push_into_empty_ready got %0d exp 1", bus_if.out1_count); end
        n_checks++; if (bus_if.out1_data !== 4'h4) begin n_fail++; $display("FAIL push_into_empty_data got %0h exp 4", bus_if.out1_data); end
        tick();
        bus_if.out0_ready = 1'b0;
        bus_if.out1_ready = 1'b0;
        n_checks++; if (bus_if.out1_count !== 3'd0) begin n_fail++; $display("FAIL steer_final_count1 got %0d exp 0", bus_if.out1_count); end
    endtask

    task automatic test_full;
        bus_if.out0_ready = 1'b0;
        bus_if.out1_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 4'(5 + i));
            #1;
            n_checks++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d] got %0h exp 1", i, bus_if.in_ready); end
            tick();
        end
        drive(1'b1, 1'b0, 4'h9);
        #1;
        n_checks++; if (bus_if.out0_count !== 3'd4) begin n_fail++; $display("FAIL full_count0 got %0d exp 4", bus_if.out0_count); end
        n_checks++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %0h exp 0", bus_if.in_ready); end
        bus_if.in_sel = 1'b1;
        #1;
        n_checks++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL other_chan_in_ready got %0h exp 1", bus_if.in_ready); end
        tick();
        drive(1'b0, 1'b0, 4'h0);
        n_checks++; if (bus_if.out1_count !== 3'd1) begin n_fail++; $display("FAIL redirect_count1 got %0d exp 1", bus_if.out1_count); end
        n_checks++; if (bus_if.out1_data !== 4'h9) begin n_fail++; $display("FAIL redirect_data got %0h exp 9", bus_if.out1_data); end
        n_checks++; if (bus_if.out0_count !== 3'd4) begin n_fail++; $display("FAIL redirect_count0 got %0d exp 4", bus_if.out0_count); end
        // full channel popped in the same cycle still refuses the push
        drive(1'b1, 1'b0, 4'hF);
        bus_if.out0_ready = 1'b1;
        #1;
        n_checks++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_bypass got %0h exp 0", bus_if.in_ready); end
        tick();
        drive(1'b0, 1'b0, 4'h0);
        n_checks++; if (bus_if.out0_count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count0 got %0d exp 3", bus_if.out0_count); end
        n_checks++; if (bus_if.out0_data !== 4'h6) begin n_fail++; $display("FAIL full_pop_head got %0h exp 6", bus_if.out0_data); end
        bus_if.out1_ready = 1'b1;
        tick();
        n_checks++; if (bus_if.out0_data !== 4'h7) begin n_fail++; $display("FAIL drain_head7 got %0h exp 7", bus_if.out0_data); end
        tick();
        n_checks++; if (bus_if.out0_data !== 4'h8) begin n_fail++; $display("FAIL drain_head8 got %0h exp 8", bus_if.out0_data); end
        tick();
        bus_if.out0_ready = 1'b0;
        bus_if.out1_ready = 1'b0;
        n_checks++; if (bus_if.out0_count !== 3'd0) begin n_fail++; $display("FAIL drain_count0 got %0d exp 0", bus_if.out0_count); end
        n_checks++; if (bus_if.out1_count !== 3'd0) begin n_fail++; $display("FAIL drain_count1 got %0d exp 0", bus_if.out1_count); end
    endtask

    task automatic test_back_to_back;
        bus_if.out0_ready = 1'b0;
        bus_if.out1_ready = 1'b0;
        drive(1'b1, 1'b0, 4'h0); tick();
        drive(1'b1, 1'b0, 4'h1); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 4'(i + 2));
            bus_if.out0_ready = 1'b1;
            #1;
            n_checks++; if (bus_if.out0_data !== 4'(i)) begin n_fail++; $display("FAIL b2b_head[%0d] got %0h exp %0h", i, bus_if.out0_data, 4'(i)); end
            n_checks++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %0h exp 1", i, bus_if.in_ready); end
            tick();
            n_checks++; if (bus_if.out0_count !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d exp 2", i, bus_if.out0_count); end
        end
        drive(1'b0, 1'b0, 4'h0);
        #1;
        n_checks++; if (bus_if.out0_data !== 4'hA) begin n_fail++; $display("FAIL b2b_tail0 got %0h exp a", bus_if.out0_data); end
        tick();
        n_checks++; if (bus_if.out0_data !== 4'hB) begin n_fail++; $display("FAIL b2b_tail1 got %0h exp b", bus_if.out0_data); end
        tick();
        bus_if.out0_ready = 1'b0;
        n_checks++; if (bus_if.out0_count !== 3'd0) begin n_fail++; $display("FAIL b2b_empty got %0d exp 0", bus_if.out0_count); end
    endtask

    task automatic test_reset_mid;
        bus_if.out0_ready = 1'b0;
        bus_if.out1_ready = 1'b0;
        drive(1'b1, 1'b0, 4'h1); tick();
        drive(1'b1, 1'b0, 4'h2); tick();
        drive(1'b1, 1'b1, 4'h4); tick();
        drive(1'b1, 1'b0, 4'h3); tick();
        drive(1'b1, 1'b1, 4'h5); tick();
        drive(1'b0, 1'b0, 4'h0);
        n_checks++; if (bus_if.out0_count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count0 got %0d exp 3", bus_if.out0_count); end
        n_checks++; if (bus_if.out1_count !== 3'd2) begin n_fail++; $display("FAIL mid_pre_count1 got %0d exp 2", bus_if.out1_count); end
        bus_if.out0_ready = 1'b1;
        bus_if.out1_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus_if.out0_valid !== 1'b0) begin n_fail++; $display("FAIL async_out0_valid got %0h exp 0", bus_if.out0_valid); end
        n_checks++; if (bus_if.out1_valid !== 1'b0) begin n_fail++; $display("FAIL async_out1_valid got %0h exp 0", bus_if.out1_valid); end
        n_checks++; if (bus_if.out0_count !== 3'd0) begin n_fail++; $display("FAIL async_count0 got %0d exp 0", bus_if.out0_count); end
        n_checks++; if (bus_if.out1_count !== 3'd0) begin n_fail++; $display("FAIL async_count1 got %0d exp 0", bus_if.out1_count); end
        n_checks++; if (bus_if.out0_data !== 4'h0) begin n_fail++; $display("FAIL async_out0_data got %0h exp 0", bus_if.out0_data); end
        n_checks++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL async_in_ready got %0h exp 1", bus_if.in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus_if.out0_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_out0_valid got %0h exp 0", bus_if.out0_valid); end
        n_checks++; if (bus_if.out1_count !== 3'd0) begin n_fail++; $display("FAIL post_rst_count1 got %0d exp 0", bus_if.out1_count); end
        bus_if.out0_ready = 1'b0;
        bus_if.out1_ready = 1'b0;
        drive(1'b1, 1'b1, 4'hC); tick();
        drive(1'b0, 1'b0, 4'h0);
        n_checks++; if (bus_if.out1_data !== 4'hC) begin n_fail++; $display("FAIL post_rst_data got %0h exp c", bus_if.out1_data); end
        n_checks++; if (bus_if.out1_count !== 3'd1) begin n_fail++; $display("FAIL post_rst_push_count got %0d exp 1", bus_if.out1_count); end
        n_checks++; if (bus_if.out0_count !== 3'd0) begin n_fail++; $display("FAIL post_rst_count0 got %0d exp 0", bus_if.out0_count); end
        bus_if.out1_ready = 1'b1;
        tick();
        bus_if.out1_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [3:0] q0[$];
        logic [3:0] q1[$];
        logic       exp_ready;
        int         errs;
        errs = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            n_checks++;
            if ((bus_if.out0_count !== 3'(q0.size())) || (bus_if.out1_count !== 3'(q1.size())) ||
                (bus_if.out0_valid !== (q0.size() != 0)) || (bus_if.out1_valid !== (q1.size() != 0))) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rand_state[%0d] got c0=%0d c1=%0d exp c0=%0d c1=%0d", cyc, bus_if.out0_count, bus_if.out1_count, q0.size(), q1.size());
            end
            drive(1'($urandom), 1'($urandom), 4'($urandom));
            bus_if.out0_ready = (q0.size() != 0) && ($urandom_range(0, 2) != 0);
            bus_if.out1_ready = (q1.size() != 0) && ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = bus_if.in_sel ? (q1.size() != 4) : (q0.size() != 4);
            n_checks++;
            if (bus_if.in_ready !== exp_ready) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rand_in_ready[%0d] got %0h exp %0h", cyc, bus_if.in_ready, exp_ready);
            end
            if (bus_if.out0_ready) begin
                n_checks++;
                if (bus_if.out0_data !== q0[0]) begin
                    n_fail++; errs++;
                    if (errs < 10) $display("FAIL rand_out0_data[%0d] got %0h exp %0h", cyc, bus_if.out0_data, q0[0]);
                end
                void'(q0.pop_front());
            end
            if (bus_if.out1_ready) begin
                n_checks++;
                if (bus_if.out1_data !== q1[0]) begin
                    n_fail++; errs++;
                    if (errs < 10) $display("FAIL rand_out1_data[%0d] got %0h exp %0h", cyc, bus_if.out1_data, q1[0]);
                end
                void'(q1.pop_front());
            end
            if (bus_if.in_valid && exp_ready) begin
                if (bus_if.in_sel) q1.push_back(bus_if.in_data);
                else q0.push_back(bus_if.in_data);
            end
            tick();
        end
        drive(1'b0, 1'b0, 4'h0);
        bus_if.out0_ready = 1'b0;
        bus_if.out1_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 4'h0);
        bus_if.out0_ready = 1'b0;
        bus_if.out1_ready = 1'b0;
        #1;
        test_reset();
        test_steering();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
